// File: rtl/pmu_i2c_arbiter.sv
// Round-robin arbiter sharing the PMU I2C byte engine among NUM_REQ requesters.
// The grant is held for a whole request sequence and is revoked by a hold watchdog.
module pmu_i2c_arbiter #(
  parameter int unsigned       NUM_REQ  = 2,
  parameter int unsigned       HOLD_W   = 16,
  parameter logic [HOLD_W-1:0] MAX_HOLD = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   abort,
  input  logic [8*NUM_REQ-1:0] rq_data,
  input  logic [NUM_REQ-1:0]   rq_start,
  input  logic [NUM_REQ-1:0]   rq_done,
  input  logic [NUM_REQ-1:0]   rq_rw,
  input  logic [NUM_REQ-1:0]   rq_clear_failed,
  output logic [NUM_REQ-1:0]   rq_data_latch,
  output logic [NUM_REQ-1:0]   rq_in_data_valid,
  output logic [NUM_REQ-1:0]   rq_ready,
  output logic [NUM_REQ-1:0]   rq_failed,
  output logic [7:0]           rq_in_data,
  output logic [7:0]           i2c_data,
  output logic                 i2c_start,
  output logic                 i2c_done,
  output logic                 i2c_clear_failed,
  output logic                 i2c_rw,
  input  logic                 i2c_data_latch,
  input  logic                 i2c_in_data_valid,
  input  logic                 i2c_ready,
  input  logic                 i2c_failed,
  input  logic [7:0]           i2c_in_data,
  output logic [1:0]           owner
);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN, ABORT} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  abort_q, abort_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [1:0]          sel_idx;
  logic [1:0]          ptr_next;
  logic [7:0]          own_data;
  logic                own_start, own_done, own_rw, own_clear, own_req;

  // Round-robin pick: smallest upward distance from the pointer wins.
  always_comb begin
    int unsigned best_d;
    int unsigned d;
    best_d  = NUM_REQ;
    d       = 0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - 32'(ptr_q)) % NUM_REQ;
      if (req[i] && (d < best_d)) begin
        best_d  = d;
        sel_idx = 2'(i);
      end
    end
  end

  always_comb begin
    own_data  = '0;
    own_start = 1'b0;
    own_done  = 1'b0;
    own_rw    = 1'b1;
    own_clear = 1'b0;
    own_req   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 2'(i)) begin
        own_data  = rq_data[8*i +: 8];
        own_start = rq_start[i];
        own_done  = rq_done[i];
        own_rw    = rq_rw[i];
        own_clear = rq_clear_failed[i];
        own_req   = req[i];
      end
    end
  end

  assign ptr_next = (owner_q == 2'(NUM_REQ - 1)) ? '0 : owner_q + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      abort_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      abort_q <= abort_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    abort_d          = '0;
    owner_d          = owner_q;
    ptr_d            = ptr_q;
    hold_d           = hold_q;
    i2c_start        = 1'b0;
    i2c_done         = 1'b0;
    i2c_clear_failed = 1'b0;
    i2c_rw           = 1'b1;
    i2c_data         = 8'h00;
    case (state_q)
      IDLE: begin
        if ((|req) && i2c_ready) begin
          state_d = OWN;
          owner_d = sel_idx;
          hold_d  = '0;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt_d[i] = (sel_idx == 2'(i));
          end
        end
      end
      OWN: begin
        i2c_start        = own_start;
        i2c_done         = own_done;
        i2c_clear_failed = own_clear;
        i2c_rw           = own_rw;
        i2c_data         = own_data;
        hold_d           = hold_q + 1'b1;
        // A req drop in the expiry cycle takes precedence over the watchdog.
        if (!own_req) begin
          state_d = DRAIN;
        end else if (hold_q == MAX_HOLD - 1'b1) begin
          state_d = ABORT;
          gnt_d   = '0;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            abort_d[i] = (owner_q == 2'(i));
          end
        end
      end
      DRAIN: begin
        i2c_done         = 1'b1;
        i2c_clear_failed = own_clear;
        i2c_rw           = own_rw;
        i2c_data         = own_data;
        if (i2c_ready) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
        end
      end
      ABORT: begin
        i2c_done         = 1'b1;
        i2c_clear_failed = 1'b1;
        if (i2c_ready) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine strobes reach only the granted requester; gnt is zero in IDLE and ABORT.
  assign rq_data_latch    = gnt_q & {NUM_REQ{i2c_data_latch}};
  assign rq_in_data_valid = gnt_q & {NUM_REQ{i2c_in_data_valid}};
  assign rq_ready         = gnt_q & {NUM_REQ{i2c_ready}};
  assign rq_failed        = gnt_q & {NUM_REQ{i2c_failed}};
  assign rq_in_data       = i2c_in_data;

  assign gnt   = gnt_q;
  assign abort = abort_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_pmu_i2c_arbiter.sv
// Directed bench for pmu_i2c_arbiter with two requesters and a 20-cycle hold watchdog.
module tb_pmu_i2c_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, gnt, abort;
  logic [15:0] rq_data;
  logic [1:0]  rq_start, rq_done, rq_rw, rq_clear_failed;
  logic [1:0]  rq_data_latch, rq_in_data_valid, rq_ready, rq_failed;
  logic [7:0]  rq_in_data, i2c_data, i2c_in_data;
  logic        i2c_start, i2c_done, i2c_clear_failed, i2c_rw;
  logic        i2c_data_latch, i2c_in_data_valid, i2c_ready, i2c_failed;
  logic [1:0]  owner;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pmu_i2c_arbiter #(.NUM_REQ(2), .HOLD_W(16), .MAX_HOLD(16'd20)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .abort(abort),
    .rq_data(rq_data), .rq_start(rq_start), .rq_done(rq_done), .rq_rw(rq_rw),
    .rq_clear_failed(rq_clear_failed), .rq_data_latch(rq_data_latch),
    .rq_in_data_valid(rq_in_data_valid), .rq_ready(rq_ready), .rq_failed(rq_failed),
    .rq_in_data(rq_in_data), .i2c_data(i2c_data), .i2c_start(i2c_start),
    .i2c_done(i2c_done), .i2c_clear_failed(i2c_clear_failed), .i2c_rw(i2c_rw),
    .i2c_data_latch(i2c_data_latch), .i2c_in_data_valid(i2c_in_data_valid),
    .i2c_ready(i2c_ready), .i2c_failed(i2c_failed), .i2c_in_data(i2c_in_data),
    .owner(owner)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    tests++; if (abort !== 2'b00) begin fails++; $display("FAIL reset_abort: got %b want 00", abort); end
    tests++; if (owner !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d want 0", owner); end
    tests++; if ({i2c_start, i2c_done, i2c_clear_failed, i2c_rw, i2c_data} !== {4'b0001, 8'h00}) begin
      fails++; $display("FAIL reset_engine: got s%b d%b c%b rw%b data%h want s0 d0 c0 rw1 data00",
                        i2c_start, i2c_done, i2c_clear_failed, i2c_rw, i2c_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] bytes [3];
    bytes = '{8'h68, 8'h10, 8'h95};
    req = 2'b01;
    i2c_ready = 1'b1;
    #1;
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL single_latency: got %b want 00", gnt); end
    tick();
    tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL single_gnt: got %b want 01", gnt); end
    tests++; if (rq_ready !== 2'b01) begin fails++; $display("FAIL single_ready: got %b want 01", rq_ready); end
    for (int b = 0; b < 3; b++) begin
      rq_data[7:0] = bytes[b];
      rq_start[0] = 1'b1;
      rq_rw[0] = 1'b1;
      i2c_data_latch = 1'b1;
      #1;
      tests++; if ({i2c_start, i2c_rw, i2c_data} !== {2'b11, bytes[b]}) begin
        fails++; $display("FAIL single_byte%0d: got s%b rw%b data%h want s1 rw1 data%h",
                          b, i2c_start, i2c_rw, i2c_data, bytes[b]);
      end
      tests++; if (rq_data_latch !== 2'b01) begin fails++; $display("FAIL single_latch%0d: got %b want 01", b, rq_data_latch); end
      tick();
      rq_start[0] = 1'b0;
      i2c_data_latch = 1'b0;
    end
    rq_done[0] = 1'b1;
    #1;
    tests++; if (i2c_done !== 1'b1) begin fails++; $display("FAIL single_done: got %b want 1", i2c_done); end
    tick();
    rq_done[0] = 1'b0;
    req = 2'b00;
    i2c_ready = 1'b0;
    tick();
    tests++; if ({gnt, i2c_start, i2c_done} !== 4'b0101) begin
      fails++; $display("FAIL single_drain: got gnt%b s%b d%b want gnt01 s0 d1", gnt, i2c_start, i2c_done);
    end
    tick();
    tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL single_drain_hold: got %b want 01", gnt); end
    i2c_ready = 1'b1;
    tick();
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL single_release: got %b want 00", gnt); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    pulse_reset();
    req = 2'b11;
    i2c_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      tests++; if (gnt !== exp) begin fails++; $display("FAIL rr_order%0d: got %b want %b", k, gnt, exp); end
      req = req & ~exp;
      tick();
      req = 2'b11;
      tick();
      tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL rr_dead%0d: got %b want 00", k, gnt); end
      tick();
    end
    req = 2'b00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_read();
    pulse_reset();
    req = 2'b11;
    i2c_ready = 1'b1;
    tick();
    tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL read_gnt: got %b want 01", gnt); end
    rq_data[7:0] = 8'h3C;
    rq_start[0] = 1'b1;
    rq_rw[0] = 1'b1;
    tick();
    rq_start[0] = 1'b0;
    rq_done[0] = 1'b1;
    tick();
    rq_done[0] = 1'b0;
    rq_start[0] = 1'b1;
    rq_rw[0] = 1'b0;
    #1;
    tests++; if ({gnt, i2c_start, i2c_rw} !== 4'b0110) begin
      fails++; $display("FAIL read_restart: got gnt%b s%b rw%b want gnt01 s1 rw0", gnt, i2c_start, i2c_rw);
    end
    tick();
    rq_start[0] = 1'b0;
    i2c_in_data = 8'h1F;
    i2c_in_data_valid = 1'b1;
    #1;
    tests++; if ({rq_in_data_valid, rq_in_data} !== {2'b01, 8'h1F}) begin
      fails++; $display("FAIL read_data: got v%b d%h want v01 d1f", rq_in_data_valid, rq_in_data);
    end
    tick();
    i2c_in_data_valid = 1'b0;
    rq_done[0] = 1'b1;
    tick();
    rq_done[0] = 1'b0;
    rq_rw[0] = 1'b1;
    req[0] = 1'b0;
    tick();
    tick();
    tick();
    tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL read_next_owner: got %b want 10", gnt); end
  endtask

  task automatic test_failure();
    rq_clear_failed = 2'b01;
    #1;
    tests++; if (i2c_clear_failed !== 1'b0) begin fails++; $display("FAIL fail_nonowner_clear: got %b want 0", i2c_clear_failed); end
    rq_clear_failed = 2'b10;
    rq_data = 16'hA55A;
    i2c_failed = 1'b1;
    #1;
    tests++; if (rq_failed !== 2'b10) begin fails++; $display("FAIL fail_route: got %b want 10", rq_failed); end
    tests++; if ({i2c_clear_failed, i2c_data} !== {1'b1, 8'hA5}) begin
      fails++; $display("FAIL fail_owner_mux: got c%b d%h want c1 da5", i2c_clear_failed, i2c_data);
    end
    tick();
    rq_clear_failed = 2'b00;
    i2c_failed = 1'b0;
    req = 2'b00;
    tick();
    tick();
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL fail_release: got %b want 00", gnt); end
  endtask

  task automatic test_watchdog();
    req = 2'b11;
    i2c_ready = 1'b1;
    tick();
    tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL wd_gnt: got %b want 01", gnt); end
    i2c_ready = 1'b0;
    for (int c = 0; c < 19; c++) tick();
    tests++; if ({gnt, abort} !== 4'b0100) begin fails++; $display("FAIL wd_early: got gnt%b abort%b want gnt01 abort00", gnt, abort); end
    tick();
    tests++; if ({gnt, abort} !== 4'b0001) begin fails++; $display("FAIL wd_abort: got gnt%b abort%b want gnt00 abort01", gnt, abort); end
    tests++; if ({i2c_start, i2c_done, i2c_clear_failed} !== 3'b011) begin
      fails++; $display("FAIL wd_engine: got s%b d%b c%b want s0 d1 c1", i2c_start, i2c_done, i2c_clear_failed);
    end
    tick();
    tests++; if ({abort, i2c_done, i2c_clear_failed} !== 4'b0011) begin
      fails++; $display("FAIL wd_hold: got abort%b d%b c%b want abort00 d1 c1", abort, i2c_done, i2c_clear_failed);
    end
    i2c_ready = 1'b1;
    #1;
    tests++; if (rq_ready !== 2'b00) begin fails++; $display("FAIL wd_no_route: got %b want 00", rq_ready); end
    tick();
    tick();
    tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL wd_next: got %b want 10", gnt); end
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 19; c++) tick();
    req = 2'b00;
    tick();
    tests++; if ({gnt, abort} !== 4'b1000) begin fails++; $display("FAIL sim_drop_wins: got gnt%b abort%b want gnt10 abort00", gnt, abort); end
    tests++; if ({i2c_done, i2c_clear_failed} !== 2'b10) begin
      fails++; $display("FAIL sim_engine: got d%b c%b want d1 c0", i2c_done, i2c_clear_failed);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_own();
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tick();
    req = 2'b11;
    tick();
    tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL rst_pre_owner: got %b want 10", gnt); end
    rq_start = 2'b10;
    #1;
    tests++; if (i2c_start !== 1'b1) begin fails++; $display("FAIL rst_pre_start: got %b want 1", i2c_start); end
    reset = 1'b1;
    tick();
    tests++; if ({gnt, abort, owner, i2c_start, i2c_done} !== 8'b00000000) begin
      fails++; $display("FAIL rst_own: got gnt%b abort%b owner%0d s%b d%b want all zero", gnt, abort, owner, i2c_start, i2c_done);
    end
    reset = 1'b0;
    rq_start = 2'b00;
    tick();
    tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL rst_ptr: got %b want 01", gnt); end
    req = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req = '0; rq_data = '0; rq_start = '0; rq_done = '0; rq_rw = '1; rq_clear_failed = '0;
    i2c_data_latch = 1'b0; i2c_in_data_valid = 1'b0; i2c_ready = 1'b0; i2c_failed = 1'b0;
    i2c_in_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_read();
    test_failure();
    test_watchdog();
    test_simultaneous();
    test_reset_own();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
